arb_mux4_rr: RTL and testbench

Round-robin arbiter that shares one 4:1 behavioural mux among four requesters. It owns the mux select. It grants one requester at a time for a bounded number of cycles and drives the selected requester's data onto the shared output with a valid flag. It sits in front of the 4:1 mux datapath as its sequencing/configuration controller.

---
 rtl/arb_mux4_rr.sv | 138 +++++++++++++
 tb/tb_arb_mux4_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux4_rr.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux4_rr
//  Description : Round-robin arbiter that owns the select of a shared 4:1 mux.
//                One requester holds the output at a time. A grant lasts until
//                the owner drops its request or has held the output for
//                MAXHOLD consecutive cycles. The selected requester's data is
//                driven onto y, qualified by valid.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                req    - request vector, req[i] = requester i wants the output
//                D      - requester data, requester i at D[i*W +: W]
//                S      - registered mux select (current/last owner index)
//                gnt    - registered one-hot grant, zero when idle
//                valid  - OR of gnt
//                y      - D[S*W +: W] when valid, else zero (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux4_rr #(
    parameter int unsigned W       = 1,
    parameter int unsigned MAXHOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [4*W-1:0]   D,
    output logic [1:0]       S,
    output logic [3:0]       gnt,
    output logic             valid,
    output logic [W-1:0]     y
);

    localparam int unsigned      CNT_W   = $clog2(MAXHOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXHOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;

    // Round-robin search starting just after the last owner. While granted,
    // last_q is the current owner, so the owner automatically ranks lowest
    // when its grant ends.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_GRANT: begin
                if (!req[last_q] || (cnt_q == CNT_MAX)) begin
                    // Grant ends: hand over at this same edge if anyone asks,
                    // including a lone owner being re-granted at MAXHOLD.
                    if (win_found) begin
                        gnt_d  = 4'b0001 << win_idx;
                        sel_d  = win_idx;
                        last_d = win_idx;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S     = sel_q;
    assign gnt   = gnt_q;
    assign valid = |gnt_q;

    always_comb begin
        y = '0;
        if (valid) begin
            y = D[sel_q*W +: W];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_mux4_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux4_rr
//  Description : Self-checking bench for arb_mux4_rr. A behavioural model
//                tracks owner / held cycles / last owner with plain integers
//                and is compared against the DUT after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux4_rr;

    localparam int W       = 4;
    localparam int MAXHOLD = 4;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] D;
    logic [1:0]     S;
    logic [3:0]     gnt;
    logic           valid;
    logic [W-1:0]   y;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_owner;   // -1 when idle
    int         m_last;
    int         m_held;
    logic [1:0] m_sel;

    arb_mux4_rr #(.W(W), .MAXHOLD(MAXHOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .D     (D),
        .S     (S),
        .gnt   (gnt),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_sel   = 2'b00;
    endtask

    function automatic int rr_pick(input int from, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (m_owner >= 0 && req[m_owner] && m_held < MAXHOLD) begin
            m_held++;
        end else begin
            w = rr_pick(m_last, req);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_sel   = 2'(w);
                m_held  = 1;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0]   e_gnt;
        logic [W-1:0] e_y;
        e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e_y   = (m_owner >= 0) ? D[m_sel*W +: W] : '0;
        chk({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        chk({tag, ".S"},     32'(S),     32'(m_sel));
        chk({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
        chk({tag, ".y"},     32'(y),     32'(e_y));
    endtask

    // One clock: model follows the edge, DUT sampled 1 ns later, then return
    // at the falling edge where the caller may change inputs.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic mid_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".gnt"},   32'(gnt),   32'h0);
        chk({tag, ".valid"}, 32'(valid), 32'h0);
        chk({tag, ".y"},     32'(y),     32'h0);
        chk({tag, ".S"},     32'(S),     32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        D     = 16'h5A3C;

        // Reset held with all requests high
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            D = 16'($urandom);
            step("reset");
        end
        chk("reset.gnt_const", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        req   = 4'b0000;
        step("idle");

        // Single requester
        D   = 16'h9C6F;
        req = 4'b0100;
        step("single");
        chk("single.gnt_const", 32'(gnt), 32'h4);
        chk("single.y_const",   32'(y),   32'hC);
        D = 16'h3B00;
        #1 chk("single.y_comb", 32'(y), 32'hB);
        req = 4'b0000;
        step("single_drop");
        chk("single_drop.S_const", 32'(S), 32'h2);

        // Rotation with all requesting
        req = 4'b1111;
        D   = 16'hF0A5;
        for (int i = 0; i < 21; i++) step("rotate");

        // Early release: owner 1 drops after two cycles while 2 waits
        req = 4'b0000;
        step("early_idle");
        req = 4'b0010;
        step("early_g1");
        step("early_g2");
        req = 4'b0100;
        step("early_hand");
        chk("early_hand.gnt_const", 32'(gnt), 32'h4);
        chk("early_hand.S_const",   32'(S),   32'h2);

        // Solo requester beyond MAXHOLD
        req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            step("solo");
            if (i > 0) chk("solo.gnt_const", 32'(gnt), 32'h1);
        end

        // Asynchronous reset mid-grant, then reset priority order
        req = 4'b0100;
        step("pre_rst");
        chk("pre_rst.gnt_const", 32'(gnt), 32'h4);
        mid_reset("async_rst");
        req = 4'b1001;
        step("post_rst");
        chk("post_rst.first", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) step("post_rst_run");
        chk("post_rst.second", 32'(gnt), 32'h8);

        // Randomized traffic with occasional async resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            D = 16'($urandom);
            if ($urandom_range(0, 99) == 0) mid_reset("rand_rst");
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
